// File: rtl/reg_file_pkg.sv
// Shared defaults and constants for the parametrised register file.
// Imported by the top level and by the read-port slice.
package reg_file_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_N_RD   = 2;
    localparam int ZERO_IDX   = 0;
endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: address mux, range and zero-register mask,
// same-cycle write forwarding and busy-bit lookup.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEF_DEPTH),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [DATA_W-1:0] regs [DEPTH],
    input  logic [DEPTH-1:0]  busy_vec,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data,
    output logic              busy
);
    logic in_range_s;
    logic zero_hit_s;
    logic byp_hit_s;

    assign in_range_s = (32'(addr) < 32'(DEPTH));
    assign zero_hit_s = (ZERO_REG != 0) && (32'(addr) == 32'(ZERO_IDX));
    // wr_valid already excludes invalid, zero-register and in-reset writes
    assign byp_hit_s  = (BYPASS != 0) && wr_valid && (wr_addr == addr);

    // Select masked, forwarded or stored value for this port
    always_comb begin
        data = {DATA_W{1'b0}};
        busy = 1'b0;
        if (!in_range_s || zero_hit_s) begin
            data = {DATA_W{1'b0}};
            busy = 1'b0;
        end else if (byp_hit_s) begin
            data = wr_data;
            busy = 1'b0;
        end else begin
            data = regs[addr];
            busy = busy_vec[addr];
        end
    end
endmodule

// File: rtl/param_reg_file.sv
// Parametrised multi-read-port register file with hardwired zero register,
// write-to-read forwarding and a per-register busy scoreboard.
module param_reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int N_RD     = DEF_N_RD,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   alloc_en,
    input  logic [ADDR_W-1:0]      alloc_addr,
    input  logic [N_RD*ADDR_W-1:0] rd_addr,
    output logic [N_RD*DATA_W-1:0] rd_data,
    output logic [N_RD-1:0]        rd_busy,
    output logic [ADDR_W:0]        busy_cnt
);
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;
    logic [DEPTH-1:0]  busy_nxt_s;
    logic [CNT_W-1:0]  busy_cnt_r;
    logic              wr_ok_s;
    logic              alloc_ok_s;
    logic              cnt_inc_s;
    logic              cnt_dec_s;

    // Writes are gated by rst_n so forwarding cannot leak data while in reset
    assign wr_ok_s = wr_en && rst_n && (32'(wr_addr) < 32'(DEPTH)) &&
                     !((ZERO_REG != 0) && (32'(wr_addr) == 32'(ZERO_IDX)));
    assign alloc_ok_s = alloc_en && (32'(alloc_addr) < 32'(DEPTH)) &&
                        !((ZERO_REG != 0) && (32'(alloc_addr) == 32'(ZERO_IDX)));

    // A new producer on the written register outranks the completing write
    assign cnt_inc_s = alloc_ok_s && !busy_r[alloc_addr];
    assign cnt_dec_s = wr_ok_s && busy_r[wr_addr] &&
                       !(alloc_ok_s && (alloc_addr == wr_addr));

    // Next-state busy vector: alloc sets, write clears, alloc wins on collision
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_ok_s && (32'(alloc_addr) == 32'(i))) begin
                busy_nxt_s[i] = 1'b1;
            end else if (wr_ok_s && (32'(wr_addr) == 32'(i))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
    end

    // Register storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_ok_s) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    // Busy scoreboard and its running population count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r     <= {DEPTH{1'b0}};
            busy_cnt_r <= {CNT_W{1'b0}};
        end else begin
            busy_r     <= busy_nxt_s;
            busy_cnt_r <= busy_cnt_r + CNT_W'(cnt_inc_s) - CNT_W'(cnt_dec_s);
        end
    end

    assign busy_cnt = busy_cnt_r;

    for (genvar g = 0; g < N_RD; g++) begin : g_rd
        reg_file_rd_port #(
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .regs     (regs_r),
            .busy_vec (busy_r),
            .addr     (rd_addr[g*ADDR_W +: ADDR_W]),
            .wr_valid (wr_ok_s),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .data     (rd_data[g*DATA_W +: DATA_W]),
            .busy     (rd_busy[g])
        );
    end
endmodule

// File: tb/tb_param_reg_file.sv
// Bench for param_reg_file: default instance (A) and a 16x12, 4-port,
// no-zero-register, no-bypass instance (B) against an array-based model.
module tb_param_reg_file;
    logic        clk;
    logic        rst_n;

    logic        a_wr_en;
    logic [4:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic        a_alloc_en;
    logic [4:0]  a_alloc_addr;
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [5:0]  a_busy_cnt;

    logic        b_wr_en;
    logic [3:0]  b_wr_addr;
    logic [15:0] b_wr_data;
    logic        b_alloc_en;
    logic [3:0]  b_alloc_addr;
    logic [15:0] b_rd_addr;
    logic [63:0] b_rd_data;
    logic [3:0]  b_rd_busy;
    logic [4:0]  b_busy_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // behavioural model state
    logic [31:0] ma_mem [32];
    bit          ma_busy[32];
    logic [15:0] mb_mem [12];
    bit          mb_busy[12];

    param_reg_file dut_a (
        .clk(clk), .rst_n(rst_n),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .alloc_en(a_alloc_en), .alloc_addr(a_alloc_addr),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .busy_cnt(a_busy_cnt)
    );

    param_reg_file #(.DATA_W(16), .DEPTH(12), .N_RD(4), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .alloc_en(b_alloc_en), .alloc_addr(b_alloc_addr),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .busy_cnt(b_busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int p, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s port%0d: got %h expected %h at %0t", nm, p, act, exp, $time);
        end
    endtask

    // model: apply the register-file rules at each edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin ma_mem[i] <= 32'h0; ma_busy[i] <= 1'b0; end
            for (int i = 0; i < 12; i++) begin mb_mem[i] <= 16'h0; mb_busy[i] <= 1'b0; end
        end else begin
            if (a_wr_en && a_wr_addr != 5'd0) begin
                ma_mem[a_wr_addr]  <= a_wr_data;
                ma_busy[a_wr_addr] <= 1'b0;
            end
            if (a_alloc_en && a_alloc_addr != 5'd0) ma_busy[a_alloc_addr] <= 1'b1;
            if (b_wr_en && b_wr_addr < 4'd12) begin
                mb_mem[b_wr_addr]  <= b_wr_data;
                mb_busy[b_wr_addr] <= 1'b0;
            end
            if (b_alloc_en && b_alloc_addr < 4'd12) mb_busy[b_alloc_addr] <= 1'b1;
        end
    end

    function automatic logic [31:0] exp_a_data(input int p);
        int ad;
        ad = int'(a_rd_addr[p*5 +: 5]);
        if (ad == 0) return 32'h0;
        if (rst_n && a_wr_en && int'(a_wr_addr) == ad) return a_wr_data;
        return ma_mem[ad];
    endfunction

    function automatic logic exp_a_busy(input int p);
        int ad;
        ad = int'(a_rd_addr[p*5 +: 5]);
        if (ad == 0) return 1'b0;
        if (rst_n && a_wr_en && int'(a_wr_addr) == ad) return 1'b0;
        return ma_busy[ad];
    endfunction

    function automatic logic [15:0] exp_b_data(input int p);
        int ad;
        ad = int'(b_rd_addr[p*4 +: 4]);
        if (ad >= 12) return 16'h0;
        return mb_mem[ad];
    endfunction

    function automatic logic exp_b_busy(input int p);
        int ad;
        ad = int'(b_rd_addr[p*4 +: 4]);
        if (ad >= 12) return 1'b0;
        return mb_busy[ad];
    endfunction

    // compare process: every cycle, after inputs settle, before the next edge
    always @(negedge clk) begin
        #3;
        if (chk_en) begin
            int ca;
            int cb;
            ca = 0;
            cb = 0;
            for (int i = 0; i < 32; i++) ca += int'(ma_busy[i]);
            for (int i = 0; i < 12; i++) cb += int'(mb_busy[i]);
            for (int p = 0; p < 2; p++) begin
                chk("model_a_rd_data", p, 64'(a_rd_data[p*32 +: 32]), 64'(exp_a_data(p)));
                chk("model_a_rd_busy", p, 64'(a_rd_busy[p]), 64'(exp_a_busy(p)));
            end
            for (int p = 0; p < 4; p++) begin
                chk("model_b_rd_data", p, 64'(b_rd_data[p*16 +: 16]), 64'(exp_b_data(p)));
                chk("model_b_rd_busy", p, 64'(b_rd_busy[p]), 64'(exp_b_busy(p)));
            end
            chk("model_a_busy_cnt", 0, 64'(a_busy_cnt), 64'(ca));
            chk("model_b_busy_cnt", 0, 64'(b_busy_cnt), 64'(cb));
        end
    end

    task automatic idle();
        a_wr_en = 1'b0; a_alloc_en = 1'b0;
        b_wr_en = 1'b0; b_alloc_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        a_wr_addr = 5'd0; a_wr_data = 32'h0; a_alloc_addr = 5'd0; a_rd_addr = 10'd0;
        b_wr_addr = 4'd0; b_wr_data = 16'h0; b_alloc_addr = 4'd0; b_rd_addr = 16'd0;
        chk_en = 1'b1;
        @(negedge clk);
        #4 chk("reset_cnt", 0, 64'(a_busy_cnt), 64'd0);
        rst_n = 1'b1;

        // reset: write reg5, alloc reg6, then async reset between edges
        @(negedge clk);
        a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hA5;
        a_alloc_en = 1'b1; a_alloc_addr = 5'd6; a_rd_addr = {5'd6, 5'd5};
        #4 chk("bypass_reg5", 0, 64'(a_rd_data[31:0]), 64'hA5);
        @(negedge clk);
        idle();
        #4;
        chk("stored_reg5", 0, 64'(a_rd_data[31:0]), 64'hA5);
        chk("busy_reg6", 1, 64'(a_rd_busy[1]), 64'd1);
        chk("cnt_after_alloc", 0, 64'(a_busy_cnt), 64'd1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_data", 0, 64'(a_rd_data[31:0]), 64'h0);
        chk("async_reset_cnt", 0, 64'(a_busy_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // fill reg k = 2k, then read adjacent pairs
        for (int k = 1; k < 32; k++) begin
            @(negedge clk);
            a_wr_en = 1'b1; a_wr_addr = 5'(k); a_wr_data = 32'(2 * k);
        end
        @(negedge clk);
        idle();
        for (int k = 1; k < 31; k++) begin
            a_rd_addr = {5'(k + 1), 5'(k)};
            #1;
            chk("fill_pair_lo", 0, 64'(a_rd_data[31:0]), 64'(2 * k));
            chk("fill_pair_hi", 1, 64'(a_rd_data[63:32]), 64'(2 * k + 2));
        end
        @(negedge clk);
        a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'h77; a_rd_addr = {5'd0, 5'd0};
        #4 chk("zero_reg_same", 0, 64'(a_rd_data[31:0]), 64'h0);
        @(negedge clk);
        idle();
        #4 chk("zero_reg_next", 0, 64'(a_rd_data[31:0]), 64'h0);

        // bypass vs. no bypass on reg7
        @(negedge clk);
        a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h1234; a_rd_addr = {5'd0, 5'd7};
        b_wr_en = 1'b1; b_wr_addr = 4'd7; b_wr_data = 16'h1234; b_rd_addr = {4'd0, 4'd0, 4'd0, 4'd7};
        #4;
        chk("bypass_a", 0, 64'(a_rd_data[31:0]), 64'h1234);
        chk("nobypass_b_old", 0, 64'(b_rd_data[15:0]), 64'h0);
        @(negedge clk);
        idle();
        #4 chk("nobypass_b_new", 0, 64'(b_rd_data[15:0]), 64'h1234);

        // scoreboard on reg3
        @(negedge clk);
        a_alloc_en = 1'b1; a_alloc_addr = 5'd3; a_rd_addr = {5'd0, 5'd3};
        @(negedge clk);
        #4;
        chk("sb_busy", 0, 64'(a_rd_busy[0]), 64'd1);
        chk("sb_cnt1", 0, 64'(a_busy_cnt), 64'd1);
        @(negedge clk);
        idle();
        #4 chk("sb_realloc_cnt", 0, 64'(a_busy_cnt), 64'd1);
        @(negedge clk);
        a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'h33;
        #4 chk("sb_wr_bypass_busy", 0, 64'(a_rd_busy[0]), 64'd0);
        @(negedge clk);
        idle();
        #4;
        chk("sb_cleared", 0, 64'(a_rd_busy[0]), 64'd0);
        chk("sb_cnt0", 0, 64'(a_busy_cnt), 64'd0);

        // alloc and write collide on reg9
        @(negedge clk);
        a_alloc_en = 1'b1; a_alloc_addr = 5'd9;
        a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'hBEEF; a_rd_addr = {5'd9, 5'd9};
        @(negedge clk);
        idle();
        #4;
        chk("coll_data", 1, 64'(a_rd_data[63:32]), 64'hBEEF);
        chk("coll_busy", 1, 64'(a_rd_busy[1]), 64'd1);
        chk("coll_cnt", 0, 64'(a_busy_cnt), 64'd1);

        // B: small config, out-of-range and non-hardwired reg0
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            b_wr_en = 1'b1; b_wr_addr = 4'(k); b_wr_data = 16'(17 * k + 16'h0070 * int'(k == 0));
        end
        @(negedge clk);
        b_wr_en = 1'b1; b_wr_addr = 4'd13; b_wr_data = 16'hFFFF;
        b_alloc_en = 1'b1; b_alloc_addr = 4'd14;
        @(negedge clk);
        b_wr_en = 1'b0; b_alloc_addr = 4'd0;
        b_rd_addr = {4'd13, 4'd3, 4'd2, 4'd1};
        #4;
        chk("b_port0", 0, 64'(b_rd_data[15:0]), 64'h11);
        chk("b_port1", 1, 64'(b_rd_data[31:16]), 64'h22);
        chk("b_port2", 2, 64'(b_rd_data[47:32]), 64'h33);
        chk("b_oor", 3, 64'(b_rd_data[63:48]), 64'h0);
        chk("b_cnt_oor_alloc", 0, 64'(b_busy_cnt), 64'd0);
        @(negedge clk);
        idle();
        b_rd_addr = {4'd0, 4'd0, 4'd0, 4'd0};
        #4;
        chk("b_reg0_data", 0, 64'(b_rd_data[15:0]), 64'h70);
        chk("b_reg0_busy", 0, 64'(b_rd_busy[0]), 64'd1);
        chk("b_reg0_cnt", 0, 64'(b_busy_cnt), 64'd1);

        // randomized phase with occasional asynchronous reset
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            a_wr_en = 1'($urandom_range(0, 1));
            a_wr_addr = 5'($urandom_range(0, 31));
            a_wr_data = $urandom;
            a_alloc_en = 1'($urandom_range(0, 1));
            a_alloc_addr = 5'($urandom_range(0, 31));
            a_rd_addr = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
            if ($urandom_range(0, 3) == 0) a_rd_addr[4:0] = a_wr_addr;
            b_wr_en = 1'($urandom_range(0, 1));
            b_wr_addr = 4'($urandom_range(0, 15));
            b_wr_data = 16'($urandom);
            b_alloc_en = 1'($urandom_range(0, 1));
            b_alloc_addr = 4'($urandom_range(0, 15));
            b_rd_addr = 16'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #1 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        idle();
        @(negedge clk);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
